// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline sequencing/hazard controller.
package proc_ctrl_pkg;

  localparam int unsigned RA_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } ctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_flush;
  } stage_ctrl_t;

  // NOP insertion: PC and IF/ID frozen, both front segments cleared to NOP.
  localparam stage_ctrl_t CTRL_NOP_HOLD = '{pc_en: 1'b0, if_id_en: 1'b0,
                                            if_id_flush: 1'b1, id_ex_flush: 1'b1};
  localparam stage_ctrl_t CTRL_BRANCH   = '{pc_en: 1'b1, if_id_en: 1'b1,
                                            if_id_flush: 1'b1, id_ex_flush: 1'b1};
  localparam stage_ctrl_t CTRL_STALL    = '{pc_en: 1'b0, if_id_en: 1'b0,
                                            if_id_flush: 1'b0, id_ex_flush: 1'b1};
  localparam stage_ctrl_t CTRL_NORMAL   = '{pc_en: 1'b1, if_id_en: 1'b1,
                                            if_id_flush: 1'b0, id_ex_flush: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the source operands in ID.
module hazard_detect #(
  parameter int unsigned RA_W = proc_ctrl_pkg::RA_W
) (
  input  logic            memread_ex,
  input  logic [RA_W-1:0] ra3_ex,
  input  logic [RA_W-1:0] ra1_id,
  input  logic [RA_W-1:0] ra2_id,
  input  logic            use_ra1_id,
  input  logic            use_ra2_id,
  output logic            load_use
);

  always_comb begin
    load_use = memread_ex &&
               ((use_ra1_id && (ra1_id == ra3_ex)) ||
                (use_ra2_id && (ra2_id == ra3_ex)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Run/halt sequencing, load-use bubbles, branch squash and post-halt drain for the
// IF/ID/EX/MEM/WB datapath, plus saturating performance counters.
module pipeline_ctrl #(
  parameter int unsigned RA_W         = proc_ctrl_pkg::RA_W,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned EVT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_flag,
  input  logic             branch_taken_ex,
  input  logic             memread_ex,
  input  logic [RA_W-1:0]  ra3_ex,
  input  logic [RA_W-1:0]  ra1_id,
  input  logic [RA_W-1:0]  ra2_id,
  input  logic             use_ra1_id,
  input  logic             use_ra2_id,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [EVT_W-1:0] stall_cnt,
  output logic [EVT_W-1:0] flush_cnt
);

  import proc_ctrl_pkg::*;

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  ctrl_state_t   state;
  logic [DW-1:0] drain_cnt;
  logic          load_use;
  stage_ctrl_t   ctrl;

  hazard_detect #(
    .RA_W(RA_W)
  ) u_hazard (
    .memread_ex (memread_ex),
    .ra3_ex     (ra3_ex),
    .ra1_id     (ra1_id),
    .ra2_id     (ra2_id),
    .use_ra1_id (use_ra1_id),
    .use_ra2_id (use_ra2_id),
    .load_use   (load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            cycle_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
          end
        end
        RUN: begin
          if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
          // A branch squashes the stalled ID instruction, so it is not counted as a stall.
          if (branch_taken_ex) begin
            if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
          end else if (load_use) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
          end
          if (halt_flag) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
          if (drain_cnt == DRAIN_LAST) begin
            state <= DONE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          if (!start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ctrl = CTRL_NOP_HOLD;
    if (state == RUN) begin
      if (branch_taken_ex)  ctrl = CTRL_BRANCH;
      else if (load_use)    ctrl = CTRL_STALL;
      else                  ctrl = CTRL_NORMAL;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign if_id_en    = ctrl.if_id_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign running     = (state == RUN);
  assign done        = (state == DONE);

endmodule
